// File: rtl/sdram_resp_pkg.sv
// sdram_resp_pkg: command encodings, ERR bit positions, mode-register fields and read-pipe entry type.
package sdram_resp_pkg;

    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LDM  = 4'b0000;

    localparam int ERR_ACT    = 0;
    localparam int ERR_IDLE   = 1;
    localparam int ERR_NOMODE = 2;
    localparam int ERR_BUSY   = 3;
    localparam int ERR_MODE   = 4;
    localparam int ERR_CLCHG  = 5;

    localparam int MR_CL_MSB = 6;
    localparam int MR_CL_LSB = 4;
    localparam int MR_BT     = 3;
    localparam int MR_BL_MSB = 2;
    localparam int MR_TM     = 7;

    localparam logic [2:0] CL_MIN = 3'd2;
    localparam logic [2:0] CL_MAX = 3'd3;

    typedef struct packed {
        logic       v;
        logic [2:0] cl;
        logic [7:0] d;
    } rd_ent_t;

    function automatic logic mode_valid(input logic [7:0] mr);
        return mr[MR_CL_MSB:MR_CL_LSB] inside {[CL_MIN:CL_MAX]} &&
               mr[MR_BL_MSB:0] == 3'd0 && !mr[MR_BT] && !mr[MR_TM];
    endfunction

endpackage

// File: rtl/sdram_resp_if.sv
// sdram_resp_if: SDRAM bus between the controller (master) and the device responder (slave).
interface sdram_resp_if;
    logic        nCS;
    logic        nRAS;
    logic        nCAS;
    logic        nWE;
    logic        CKE;
    logic [1:0]  BA;
    logic [12:0] RA;
    logic        DQMH;
    logic        DQML;
    logic [7:0]  RDI;
    logic [7:0]  RDO;
    logic        RDOE;
    logic        MODEOK;
    logic [15:0] REFCNT;
    logic [5:0]  ERR;

    modport master (
        output nCS, nRAS, nCAS, nWE, CKE, BA, RA, DQMH, DQML, RDI,
        input  RDO, RDOE, MODEOK, REFCNT, ERR
    );

    modport slave (
        input  nCS, nRAS, nCAS, nWE, CKE, BA, RA, DQMH, DQML, RDI,
        output RDO, RDOE, MODEOK, REFCNT, ERR
    );
endinterface

// File: rtl/sdram_resp_rdpipe.sv
// sdram_resp_rdpipe: issue stage, delay stage and output register; each entry carries the CL it was issued with.
module sdram_resp_rdpipe
    import sdram_resp_pkg::*;
(
    input  logic       C8M,
    input  logic       nRESET,
    input  logic       issue,
    input  logic [2:0] cl,
    input  logic [7:0] din,
    output logic [7:0] rdo,
    output logic       rdoe,
    output logic       busy
);
    rd_ent_t    p0_q, p0_d, p1_q, p1_d;
    logic [7:0] rdo_q, rdo_d;
    logic       rdoe_q, rdoe_d;
    logic       tap2, tap3;

    // CL2 entries leave from the issue stage, CL3 entries take one extra stage.
    always_comb begin
        p0_d   = issue ? '{v: 1'b1, cl: cl, d: din} : '0;
        p1_d   = (p0_q.v && p0_q.cl != CL_MIN) ? p0_q : '0;
        tap3   = p1_q.v && p1_q.cl == CL_MAX;
        tap2   = p0_q.v && p0_q.cl == CL_MIN;
        rdoe_d = tap3 || tap2;
        rdo_d  = tap3 ? p1_q.d : tap2 ? p0_q.d : 8'h00;
    end

    always_ff @(posedge C8M) begin
        if (!nRESET) begin
            p0_q   <= '0;
            p1_q   <= '0;
            rdo_q  <= '0;
            rdoe_q <= 1'b0;
        end else begin
            p0_q   <= p0_d;
            p1_q   <= p1_d;
            rdo_q  <= rdo_d;
            rdoe_q <= rdoe_d;
        end
    end

    assign rdo  = rdo_q;
    assign rdoe = rdoe_q;
    assign busy = p0_q.v || p1_q.v;
endmodule

// File: rtl/sdram_resp.sv
// sdram_resp: SDR SDRAM device responder -- command decode, bank/mode state, byte array, REFCNT/ERR.
// Define SDRAM_RESP_TIMING_CHK_EN to add per-bank TRCD/TRP violation flags.
module sdram_resp
    import sdram_resp_pkg::*;
#(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 4,
    parameter int TRCD     = 1,
    parameter int TRP      = 1
) (
    input  logic        C8M,
    input  logic        nRESET,
    sdram_resp_if.slave bus
);
    localparam int AW = 3 + ROW_BITS + COL_BITS;

    logic                     cke_q;
    logic [3:0]               open_q, open_d;
    logic [3:0][ROW_BITS-1:0] row_q, row_d;
    logic                     mode_ok_q, mode_ok_d;
    logic [2:0]               cl_q, cl_d;
    logic [15:0]              refcnt_q, refcnt_d;
    logic [5:0]               err_q, err_d;
    logic                     rd_issue, wr_en, rd_busy;
    logic [3:0]               cmd;
    logic [AW-2:0]            base;
    logic [7:0]               rd_data;
    logic [7:0]               mem [2**AW];
    logic                     unused_ra;

`ifdef SDRAM_RESP_TIMING_CHK_EN
    localparam logic [3:0] TRCD_C = 4'(TRCD);
    localparam logic [3:0] TRP_C  = 4'(TRP);
    logic [3:0][3:0] act_age_q, act_age_d, pre_age_q, pre_age_d;
`else
    localparam int unused_timing = TRCD + TRP;
`endif

    assign cmd       = {bus.nCS, bus.nRAS, bus.nCAS, bus.nWE};
    assign base      = {bus.BA, row_q[bus.BA], bus.RA[COL_BITS-1:0]};
    assign rd_data   = mem[{base, bus.DQML}];
    assign unused_ra = ^{bus.RA[12:11], bus.RA[9:8]};

    always_comb begin
        open_d    = open_q;
        row_d     = row_q;
        mode_ok_d = mode_ok_q;
        cl_d      = cl_q;
        refcnt_d  = refcnt_q;
        err_d     = err_q;
        rd_issue  = 1'b0;
        wr_en     = 1'b0;
`ifdef SDRAM_RESP_TIMING_CHK_EN
        for (int b = 0; b < 4; b++) begin
            act_age_d[b] = act_age_q[b] + 4'(act_age_q[b] != 4'hF);
            pre_age_d[b] = pre_age_q[b] + 4'(pre_age_q[b] != 4'hF);
        end
`endif
        if (cke_q) begin
            if (!mode_ok_q && (cmd == CMD_ACT || cmd == CMD_RD || cmd == CMD_WR || cmd == CMD_AREF))
                err_d[ERR_NOMODE] = 1'b1;
            else begin
                case (cmd)
                    CMD_ACT: begin
                        if (open_q[bus.BA])
                            err_d[ERR_ACT] = 1'b1;
                        else begin
                            open_d[bus.BA] = 1'b1;
                            row_d[bus.BA]  = bus.RA[ROW_BITS-1:0];
`ifdef SDRAM_RESP_TIMING_CHK_EN
                            act_age_d[bus.BA] = 4'd1;
                            if (pre_age_q[bus.BA] < TRP_C) err_d[ERR_BUSY] = 1'b1;
`endif
                        end
                    end
                    CMD_RD, CMD_WR: begin
                        if (!open_q[bus.BA])
                            err_d[ERR_IDLE] = 1'b1;
                        else begin
                            rd_issue = cmd == CMD_RD && !(bus.DQML && bus.DQMH);
                            wr_en    = cmd == CMD_WR;
`ifdef SDRAM_RESP_TIMING_CHK_EN
                            if (act_age_q[bus.BA] < TRCD_C) err_d[ERR_ACT] = 1'b1;
`endif
                        end
                    end
                    CMD_PRE: begin
                        for (int b = 0; b < 4; b++)
                            if (bus.RA[10] || bus.BA == 2'(b)) begin
                                open_d[b] = 1'b0;
`ifdef SDRAM_RESP_TIMING_CHK_EN
                                pre_age_d[b] = 4'd1;
`endif
                            end
                    end
                    CMD_AREF: begin
                        if (|open_q) err_d[ERR_BUSY] = 1'b1;
`ifdef SDRAM_RESP_TIMING_CHK_EN
                        for (int b = 0; b < 4; b++)
                            if (pre_age_q[b] < TRP_C) err_d[ERR_BUSY] = 1'b1;
`endif
                        refcnt_d = refcnt_q + 16'(refcnt_q != 16'hFFFF);
                    end
                    CMD_LDM: begin
                        if (|open_q)
                            err_d[ERR_BUSY] = 1'b1;
                        else if (mode_valid(bus.RA[7:0])) begin
                            mode_ok_d = 1'b1;
                            cl_d      = bus.RA[MR_CL_MSB:MR_CL_LSB];
                            if (rd_busy && cl_d != cl_q) err_d[ERR_CLCHG] = 1'b1;
                        end else begin
                            mode_ok_d       = 1'b0;
                            err_d[ERR_MODE] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge C8M) begin
        if (!nRESET) begin
            cke_q     <= 1'b0;
            open_q    <= '0;
            row_q     <= '0;
            mode_ok_q <= 1'b0;
            cl_q      <= CL_MIN;
            refcnt_q  <= '0;
            err_q     <= '0;
`ifdef SDRAM_RESP_TIMING_CHK_EN
            act_age_q <= '1;
            pre_age_q <= '1;
`endif
        end else begin
            cke_q     <= bus.CKE;
            open_q    <= open_d;
            row_q     <= row_d;
            mode_ok_q <= mode_ok_d;
            cl_q      <= cl_d;
            refcnt_q  <= refcnt_d;
            err_q     <= err_d;
`ifdef SDRAM_RESP_TIMING_CHK_EN
            act_age_q <= act_age_d;
            pre_age_q <= pre_age_d;
`endif
        end
    end

    // Array has no reset; both masks low writes the byte to both lanes.
    always_ff @(posedge C8M) begin
        if (nRESET && wr_en) begin
            if (!bus.DQML) mem[{base, 1'b0}] <= bus.RDI;
            if (!bus.DQMH) mem[{base, 1'b1}] <= bus.RDI;
        end
    end

    sdram_resp_rdpipe u_rdpipe (
        .C8M    (C8M),
        .nRESET (nRESET),
        .issue  (rd_issue),
        .cl     (cl_q),
        .din    (rd_data),
        .rdo    (bus.RDO),
        .rdoe   (bus.RDOE),
        .busy   (rd_busy)
    );

    assign bus.MODEOK = mode_ok_q;
    assign bus.REFCNT = refcnt_q;
    assign bus.ERR    = err_q;
endmodule

// File: tb/tb_sdram_resp.sv
// tb_sdram_resp: scoreboard bench for sdram_resp; read expectations queued at issue, checked when due.
module tb_sdram_resp;
    import sdram_resp_pkg::*;

    logic C8M = 1'b0;
    logic nRESET = 1'b0;
    sdram_resp_if bus ();

    sdram_resp #(.ROW_BITS(4), .COL_BITS(4), .TRCD(2), .TRP(1)) dut (
        .C8M    (C8M),
        .nRESET (nRESET),
        .bus    (bus)
    );

    always #5 C8M = ~C8M;

`ifdef SDRAM_RESP_TIMING_CHK_EN
    localparam logic [5:0] TRCD_ERR = 6'h01;
`else
    localparam logic [5:0] TRCD_ERR = 6'h00;
`endif

    typedef struct {
        int         due;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         edge_n = 0;
    int         cur_cl = 2;
    logic [7:0] mdl[int];
    logic [3:0] mrow[4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    always @(posedge C8M) begin
        edge_n++;
        #1;
        if (sb.size() > 0 && sb[0].due == edge_n) begin
            chk("rdoe", 32'(bus.RDOE), 32'd1);
            chk("rdo", 32'(bus.RDO), 32'(sb[0].d));
            void'(sb.pop_front());
        end else if (bus.RDOE)
            chk("rdoe_spurious", 32'(bus.RDOE), 32'd0);
    end

    function automatic int key(input logic [1:0] ba, input logic [3:0] col, input logic lane);
        return int'({ba, mrow[ba], col, lane});
    endfunction

    task automatic issue(input logic [3:0] c, input logic [1:0] ba = 2'd0, input logic [12:0] ra = 13'd0,
                         input logic dqml = 1'b0, input logic dqmh = 1'b0, input logic [7:0] d = 8'h00,
                         input logic cke = 1'b1);
        {bus.nCS, bus.nRAS, bus.nCAS, bus.nWE} = c;
        bus.BA = ba;
        bus.RA = ra;
        bus.DQML = dqml;
        bus.DQMH = dqmh;
        bus.RDI = d;
        bus.CKE = cke;
        @(posedge C8M);
        #1;
    endtask

    task automatic nop(input logic cke = 1'b1);
        issue(4'b0111, 2'd0, 13'd0, 1'b0, 1'b0, 8'h00, cke);
    endtask

    task automatic act(input logic [1:0] ba, input logic [3:0] row);
        mrow[ba] = row;
        issue(CMD_ACT, ba, 13'(row));
    endtask

    task automatic wr(input logic [1:0] ba, input logic [3:0] col, input logic dqml, input logic dqmh,
                      input logic [7:0] d);
        if (!dqml) mdl[key(ba, col, 1'b0)] = d;
        if (!dqmh) mdl[key(ba, col, 1'b1)] = d;
        issue(CMD_WR, ba, 13'(col), dqml, dqmh, d);
    endtask

    task automatic rd(input logic [1:0] ba, input logic [3:0] col, input logic dqml, input logic dqmh,
                      input logic ok);
        if (ok) sb.push_back('{edge_n + cur_cl, mdl[key(ba, col, dqml)]});
        issue(CMD_RD, ba, 13'(col), dqml, dqmh);
    endtask

    task automatic ldm(input logic [12:0] ra, input int new_cl);
        issue(CMD_LDM, 2'd0, ra);
        cur_cl = new_cl;
    endtask

    task automatic do_reset();
        nRESET = 1'b0;
        nop();
        nop();
        nRESET = 1'b1;
        nop();
        cur_cl = 2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        chk("rst_rdo", 32'(bus.RDO), 32'd0);
        chk("rst_rdoe", 32'(bus.RDOE), 32'd0);
        chk("rst_modeok", 32'(bus.MODEOK), 32'd0);
        chk("rst_refcnt", 32'(bus.REFCNT), 32'd0);
        chk("rst_err", 32'(bus.ERR), 32'd0);

        ldm(13'h0220, 2);
        chk("ldm_cl2_modeok", 32'(bus.MODEOK), 32'd1);
        act(2'd1, 4'd5);
        nop();
        nop();
        wr(2'd1, 4'd3, 1'b0, 1'b1, 8'hA5);
        nop();
        rd(2'd1, 4'd3, 1'b0, 1'b1, 1'b1);
        nop();
        nop();
        wr(2'd1, 4'd3, 1'b1, 1'b0, 8'h3C);
        wr(2'd1, 4'd4, 1'b0, 1'b0, 8'h77);
        rd(2'd1, 4'd4, 1'b1, 1'b0, 1'b1);
        rd(2'd1, 4'd3, 1'b1, 1'b0, 1'b1);
        rd(2'd1, 4'd3, 1'b0, 1'b0, 1'b1);
        rd(2'd1, 4'd4, 1'b1, 1'b1, 1'b0);
        wr(2'd1, 4'd3, 1'b1, 1'b1, 8'hFF);
        rd(2'd1, 4'd3, 1'b0, 1'b1, 1'b1);
        wr(2'd1, 4'd5, 1'b0, 1'b0, 8'h11);
        rd(2'd1, 4'd5, 1'b0, 1'b0, 1'b1);
        wr(2'd1, 4'd5, 1'b0, 1'b0, 8'h22);
        rd(2'd1, 4'd5, 1'b0, 1'b0, 1'b1);
        repeat (3) nop();
        chk("err_clean", 32'(bus.ERR), 32'h00);
        issue(CMD_ACT, 2'd1, 13'd9);
        chk("err_act_open", 32'(bus.ERR), 32'h01);
        rd(2'd1, 4'd3, 1'b0, 1'b1, 1'b1);
        repeat (3) nop();

        rd(2'd1, 4'd3, 1'b0, 1'b1, 1'b0);
        nRESET = 1'b0;
        nop();
        chk("squash_rdoe", 32'(bus.RDOE), 32'd0);
        nop();
        nRESET = 1'b1;
        nop();
        cur_cl = 2;
        chk("squash_err", 32'(bus.ERR), 32'h00);
        chk("squash_modeok", 32'(bus.MODEOK), 32'd0);

        rd(2'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("err_nomode", 32'(bus.ERR), 32'h04);
        ldm(13'h0220, 2);
        rd(2'd2, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("err_idle", 32'(bus.ERR), 32'h06);
        ldm(13'h0230, 3);
        chk("ldm_cl3_modeok", 32'(bus.MODEOK), 32'd1);
        act(2'd0, 4'd2);
        nop();
        nop();
        wr(2'd0, 4'd1, 1'b0, 1'b0, 8'hC3);
        wr(2'd0, 4'd2, 1'b0, 1'b0, 8'h5A);
        rd(2'd0, 4'd1, 1'b0, 1'b0, 1'b1);
        rd(2'd0, 4'd2, 1'b0, 1'b0, 1'b1);
        nop();
        rd(2'd0, 4'd1, 1'b0, 1'b0, 1'b1);
        issue(CMD_PRE, 2'd0, 13'h0400);
        ldm(13'h0220, 2);
        chk("err_clchg", 32'(bus.ERR), 32'h26);
        repeat (3) nop();
        ldm(13'h0250, 2);
        chk("err_badmode", 32'(bus.ERR), 32'h36);
        chk("badmode_modeok", 32'(bus.MODEOK), 32'd0);

        do_reset();
        ldm(13'h0220, 2);
        for (int i = 0; i < 300; i++) begin
            nop(1'b0);
            nop(1'b1);
            issue(CMD_AREF);
        end
        chk("refcnt_300", 32'(bus.REFCNT), 32'd300);
        chk("aref_err", 32'(bus.ERR), 32'h00);
        nop(1'b0);
        issue(CMD_ACT, 2'd3, 13'd1);
        nop();
        rd(2'd3, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("cke_act_ignored", 32'(bus.ERR), 32'h02);
        act(2'd3, 4'd1);
        nop();
        issue(CMD_AREF);
        chk("aref_busy_err", 32'(bus.ERR), 32'h0A);
        chk("refcnt_301", 32'(bus.REFCNT), 32'd301);

        do_reset();
        ldm(13'h0220, 2);
        act(2'd0, 4'd3);
        nop();
        nop();
        wr(2'd0, 4'd1, 1'b0, 1'b0, 8'h9E);
        issue(CMD_PRE, 2'd0, 13'h0000);
        nop();
        act(2'd0, 4'd3);
        rd(2'd0, 4'd1, 1'b0, 1'b0, 1'b1);
        repeat (3) nop();
        chk("trcd_err", 32'(bus.ERR), 32'(TRCD_ERR));

        repeat (4) nop();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
